// File: rtl/dm_sba_ctrl_pkg.sv
// Shared types, error codes and lane helpers for the debug-module system bus access sequencer.
package dm_sba_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } sba_state_e;

    localparam logic [2:0] SBERR_NONE    = 3'd0;
    localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
    localparam logic [2:0] SBERR_BADADDR = 3'd2;
    localparam logic [2:0] SBERR_ALIGN   = 3'd3;
    localparam logic [2:0] SBERR_SIZE    = 3'd4;

    // Byte enables for a write of the given size, placed at the byte offset.
    function automatic logic [3:0] sba_be(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] base;
        case (size)
            3'd0:    base = 4'b0001;
            3'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << off;
    endfunction

    function automatic logic sba_align_ok(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            3'd1:    return !addr[0];
            3'd2:    return addr == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_sba_ctrl_timeout.sv
// Cycle counter for bus-access timeouts: cleared while idle, counts while busy.
module dm_sba_timeout #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Fires in the last counted cycle so the access has been busy for exactly LIMIT cycles.
    assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/dm_sba_ctrl.sv
// System bus access sequencer: one sized access at a time over a req/gnt/rvalid master port.
module dm_sba_ctrl
    import dm_sba_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] sbaddress_i,
    input  logic [31:0] sbdata_i,
    input  logic [2:0]  sbaccess_i,
    input  logic        sbautoincrement_i,
    input  logic        sbreadonaddr_i,
    input  logic        sbreadondata_i,
    input  logic        sbaddress_write_valid_i,
    input  logic        sbdata_read_valid_i,
    input  logic        sbdata_write_valid_i,
    output logic        sbbusy_o,
    output logic [2:0]  sberror_o,
    output logic        sberror_valid_o,
    output logic [31:0] sbdata_o,
    output logic        sbdata_valid_o,
    output logic [31:0] sbaddress_o,
    output logic        sbaddress_update_o,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic        err_i,
    input  logic [31:0] rdata_i,
    output logic [1:0]  dbg_state
);
    // Bus protocol: req_o stays high with stable addr/we/wdata/be until gnt_i is
    // sampled high; exactly one rvalid_i response follows in a later cycle.

    sba_state_e  state;
    logic [31:0] op_addr;
    logic [1:0]  op_size;
    logic        op_write;
    logic        op_inc;
    logic        trigger;
    logic        expired;
    logic [31:0] rd_shift;
    logic [31:0] rd_data;

    assign trigger = sbdata_write_valid_i
                   || (sbaddress_write_valid_i && sbreadonaddr_i)
                   || (sbdata_read_valid_i && sbreadondata_i);
    assign sbbusy_o  = (state != IDLE);
    assign dbg_state = state;

    assign rd_shift = rdata_i >> {op_addr[1:0], 3'b000};
    always_comb begin
        rd_data = rd_shift;
        case (op_size)
            2'd0:    rd_data = {24'h0, rd_shift[7:0]};
            2'd1:    rd_data = {16'h0, rd_shift[15:0]};
            default: rd_data = rd_shift;
        endcase
    end

    dm_sba_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (state == IDLE),
        .enable  (state != IDLE),
        .expired (expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= IDLE;
            op_addr            <= '0;
            op_size            <= '0;
            op_write           <= 1'b0;
            op_inc             <= 1'b0;
            sberror_o          <= SBERR_NONE;
            sberror_valid_o    <= 1'b0;
            sbdata_o           <= '0;
            sbdata_valid_o     <= 1'b0;
            sbaddress_o        <= '0;
            sbaddress_update_o <= 1'b0;
            req_o              <= 1'b0;
            we_o               <= 1'b0;
            addr_o             <= '0;
            wdata_o            <= '0;
            be_o               <= '0;
        end else begin
            sberror_valid_o    <= 1'b0;
            sbdata_valid_o     <= 1'b0;
            sbaddress_update_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        if (sbaccess_i > 3'd2) begin
                            sberror_o       <= SBERR_SIZE;
                            sberror_valid_o <= 1'b1;
                        end else if (!sba_align_ok(sbaccess_i, sbaddress_i[1:0])) begin
                            sberror_o       <= SBERR_ALIGN;
                            sberror_valid_o <= 1'b1;
                        end else begin
                            state    <= REQ;
                            op_addr  <= sbaddress_i;
                            op_size  <= sbaccess_i[1:0];
                            op_write <= sbdata_write_valid_i;
                            op_inc   <= sbautoincrement_i;
                            req_o    <= 1'b1;
                            we_o     <= sbdata_write_valid_i;
                            addr_o   <= {sbaddress_i[31:2], 2'b00};
                            wdata_o  <= sbdata_i << {sbaddress_i[1:0], 3'b000};
                            be_o     <= sbdata_write_valid_i ?
                                        sba_be(sbaccess_i, sbaddress_i[1:0]) : 4'b1111;
                        end
                    end
                end
                REQ: begin
                    if (expired) begin
                        state           <= IDLE;
                        req_o           <= 1'b0;
                        sberror_o       <= SBERR_TIMEOUT;
                        sberror_valid_o <= 1'b1;
                    end else if (gnt_i) begin
                        state <= WAIT;
                        req_o <= 1'b0;
                    end
                end
                WAIT: begin
                    // A response in the final timeout cycle still counts as arrived.
                    if (rvalid_i) begin
                        state <= IDLE;
                        if (err_i) begin
                            sberror_o       <= SBERR_BADADDR;
                            sberror_valid_o <= 1'b1;
                        end else begin
                            if (!op_write) begin
                                sbdata_o       <= rd_data;
                                sbdata_valid_o <= 1'b1;
                            end
                            if (op_inc) begin
                                sbaddress_o        <= op_addr + (32'd1 << op_size);
                                sbaddress_update_o <= 1'b1;
                            end
                        end
                    end else if (expired) begin
                        state           <= IDLE;
                        sberror_o       <= SBERR_TIMEOUT;
                        sberror_valid_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Directed bench for the system bus access sequencer, with a short timeout.
module tb_dm_sba_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sbaddress = '0;
    logic [31:0] sbdata = '0;
    logic [2:0]  sbaccess = '0;
    logic        autoinc = 1'b0;
    logic        readonaddr = 1'b0;
    logic        readondata = 1'b0;
    logic        aw_valid = 1'b0;
    logic        dr_valid = 1'b0;
    logic        dw_valid = 1'b0;
    logic        busy;
    logic [2:0]  sberror;
    logic        sberror_valid;
    logic [31:0] sbdata_out;
    logic        sbdata_valid;
    logic [31:0] sbaddress_out;
    logic        sbaddress_update;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic        err = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_sba_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .sbaddress_i             (sbaddress),
        .sbdata_i                (sbdata),
        .sbaccess_i              (sbaccess),
        .sbautoincrement_i       (autoinc),
        .sbreadonaddr_i          (readonaddr),
        .sbreadondata_i          (readondata),
        .sbaddress_write_valid_i (aw_valid),
        .sbdata_read_valid_i     (dr_valid),
        .sbdata_write_valid_i    (dw_valid),
        .sbbusy_o                (busy),
        .sberror_o               (sberror),
        .sberror_valid_o         (sberror_valid),
        .sbdata_o                (sbdata_out),
        .sbdata_valid_o          (sbdata_valid),
        .sbaddress_o             (sbaddress_out),
        .sbaddress_update_o      (sbaddress_update),
        .req_o                   (req),
        .we_o                    (we),
        .addr_o                  (addr),
        .wdata_o                 (wdata),
        .be_o                    (be),
        .gnt_i                   (gnt),
        .rvalid_i                (rvalid),
        .err_i                   (err),
        .rdata_i                 (rdata),
        .dbg_state               (dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        rst = 1'b1;
        step();
        step();
        checks++;
        obs = {24'h0, req, we, busy, sberror_valid, sbdata_valid, sbaddress_update, dbg_state};
        if (obs !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got %h expected %h", obs, 32'h0);
        end
        checks++;
        obs = addr | wdata | sbdata_out | sbaddress_out | {25'h0, sberror, be};
        if (obs !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected %h", obs, 32'h0);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write32();
        sbaddress = 32'h1000_0004; sbdata = 32'hDEAD_BEEF; sbaccess = 3'd2; autoinc = 1'b0;
        dw_valid = 1'b1;
        step();
        dw_valid = 1'b0;
        checks++;
        if ({req, busy, we, be} !== 7'b111_1111) begin
            errors++;
            $display("FAIL w32_start: got %b expected %b", {req, busy, we, be}, 7'b111_1111);
        end
        checks++;
        if ({addr, wdata} !== {32'h1000_0004, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL w32_bus: got %h %h expected 10000004 deadbeef", addr, wdata);
        end
        step();
        // A trigger while busy must be ignored.
        dw_valid = 1'b1; sbdata = 32'h1111_1111;
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL w32_hold2: got %b expected 1", req);
        end
        step();
        dw_valid = 1'b0;
        gnt = 1'b1;
        checks++;
        if ({req, wdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL w32_hold3: got %b %h expected 1 deadbeef", req, wdata);
        end
        step();
        gnt = 1'b0;
        checks++;
        if ({req, busy} !== 2'b01) begin
            errors++;
            $display("FAIL w32_wait: got %b expected 01", {req, busy});
        end
        rvalid = 1'b1;
        step();
        rvalid = 1'b0;
        checks++;
        if ({busy, sbdata_valid, sberror_valid, sbaddress_update} !== 4'b0000) begin
            errors++;
            $display("FAIL w32_done: got %b expected 0000",
                     {busy, sbdata_valid, sberror_valid, sbaddress_update});
        end
        step();
        checks++;
        if ({busy, req} !== 2'b00) begin
            errors++;
            $display("FAIL w32_ignored_trig: got %b expected 00", {busy, req});
        end
    endtask

    task automatic test_read8_autoinc();
        sbaddress = 32'h2000_0003; sbaccess = 3'd0; autoinc = 1'b1; readondata = 1'b1;
        dr_valid = 1'b1;
        step();
        dr_valid = 1'b0;
        checks++;
        if ({req, we, be, addr} !== {1'b1, 1'b0, 4'b1111, 32'h2000_0000}) begin
            errors++;
            $display("FAIL r8_start: got %b %b %b %h expected 1 0 1111 20000000", req, we, be, addr);
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'hAB00_0000;
        step();
        rvalid = 1'b0; rdata = '0;
        checks++;
        if ({sbdata_valid, sbdata_out} !== {1'b1, 32'h0000_00AB}) begin
            errors++;
            $display("FAIL r8_data: got %b %h expected 1 000000ab", sbdata_valid, sbdata_out);
        end
        checks++;
        if ({sbaddress_update, sbaddress_out, busy} !== {1'b1, 32'h2000_0004, 1'b0}) begin
            errors++;
            $display("FAIL r8_inc: got %b %h %b expected 1 20000004 0",
                     sbaddress_update, sbaddress_out, busy);
        end
        step();
        checks++;
        if ({sbdata_valid, sbaddress_update} !== 2'b00) begin
            errors++;
            $display("FAIL r8_strobe_len: got %b expected 00", {sbdata_valid, sbaddress_update});
        end
        readondata = 1'b0;
    endtask

    task automatic test_write16_lanes();
        sbaddress = 32'h4000_0002; sbdata = 32'h0000_1234; sbaccess = 3'd1; autoinc = 1'b1;
        dw_valid = 1'b1;
        step();
        dw_valid = 1'b0;
        checks++;
        if ({be, wdata, addr} !== {4'b1100, 32'h1234_0000, 32'h4000_0000}) begin
            errors++;
            $display("FAIL w16_lanes: got %b %h %h expected 1100 12340000 40000000", be, wdata, addr);
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rvalid = 1'b1;
        step();
        rvalid = 1'b0;
        checks++;
        if ({sbaddress_update, sbaddress_out, sbdata_valid} !== {1'b1, 32'h4000_0004, 1'b0}) begin
            errors++;
            $display("FAIL w16_inc: got %b %h %b expected 1 40000004 0",
                     sbaddress_update, sbaddress_out, sbdata_valid);
        end
        autoinc = 1'b0;
        step();
    endtask

    task automatic test_precheck();
        sbaddress = 32'h0000_3001; sbaccess = 3'd1;
        dw_valid = 1'b1;
        step();
        dw_valid = 1'b0;
        checks++;
        if ({sberror_valid, sberror, req, busy} !== {1'b1, 3'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL align_err: got %b %0d %b %b expected 1 3 0 0", sberror_valid, sberror, req, busy);
        end
        step();
        checks++;
        if ({sberror_valid, req, busy} !== 3'b000) begin
            errors++;
            $display("FAIL align_after: got %b expected 000", {sberror_valid, req, busy});
        end
        sbaddress = 32'h0000_3000; sbaccess = 3'd3;
        dw_valid = 1'b1;
        step();
        dw_valid = 1'b0;
        checks++;
        if ({sberror_valid, sberror, req, busy} !== {1'b1, 3'd4, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL size_err: got %b %0d %b %b expected 1 4 0 0", sberror_valid, sberror, req, busy);
        end
        // Address write without readonaddr starts nothing.
        sbaccess = 3'd2; readonaddr = 1'b0;
        aw_valid = 1'b1;
        step();
        aw_valid = 1'b0;
        checks++;
        if ({busy, req, sberror_valid} !== 3'b000) begin
            errors++;
            $display("FAIL aw_no_read: got %b expected 000", {busy, req, sberror_valid});
        end
    endtask

    task automatic test_timeout();
        int busy_cycles;
        sbaddress = 32'h5000_0000; sbaccess = 3'd2; readonaddr = 1'b1;
        aw_valid = 1'b1;
        step();
        aw_valid = 1'b0;
        gnt = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 12 && busy; i++) begin
            busy_cycles++;
            step();
            gnt = 1'b0;
        end
        checks++;
        if (busy_cycles !== 8) begin
            errors++;
            $display("FAIL timeout_len: got %0d busy cycles expected 8", busy_cycles);
        end
        checks++;
        if ({sberror_valid, sberror, req, busy} !== {1'b1, 3'd1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_err: got %b %0d %b %b expected 1 1 0 0", sberror_valid, sberror, req, busy);
        end
        rvalid = 1'b1; rdata = 32'hCAFE_F00D;
        step();
        rvalid = 1'b0; rdata = '0;
        checks++;
        if ({sbdata_valid, sberror_valid, busy, sbaddress_update} !== 4'b0000) begin
            errors++;
            $display("FAIL late_rvalid: got %b expected 0000",
                     {sbdata_valid, sberror_valid, busy, sbaddress_update});
        end
        readonaddr = 1'b0;
    endtask

    task automatic test_bus_error();
        sbaddress = 32'h6000_0000; sbaccess = 3'd2; autoinc = 1'b1; readondata = 1'b1;
        dr_valid = 1'b1;
        step();
        dr_valid = 1'b0;
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rvalid = 1'b1; err = 1'b1; rdata = 32'h1234_5678;
        step();
        rvalid = 1'b0; err = 1'b0; rdata = '0;
        checks++;
        if ({sberror_valid, sberror, sbdata_valid, sbaddress_update, busy} !== {1'b1, 3'd2, 3'b000}) begin
            errors++;
            $display("FAIL bus_err: got %b %0d %b %b %b expected 1 2 0 0 0",
                     sberror_valid, sberror, sbdata_valid, sbaddress_update, busy);
        end
        autoinc = 1'b0; readondata = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        sbaddress = 32'h0000_0100; sbdata = 32'hA5A5_A5A5; sbaccess = 3'd2;
        dw_valid = 1'b1;
        step();
        dw_valid = 1'b0;
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if ({req, busy, we, be, addr, wdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %b %b %b %b %h %h expected all zero", req, busy, we, be, addr, wdata);
        end
        rst = 1'b0;
        rvalid = 1'b1;
        step();
        rvalid = 1'b0;
        checks++;
        if ({busy, sbdata_valid, sberror_valid, sbaddress_update} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_discard: got %b expected 0000",
                     {busy, sbdata_valid, sberror_valid, sbaddress_update});
        end
    endtask

    task automatic test_back_to_back();
        sbaddress = 32'hFFFF_FFFC; sbdata = 32'h0000_0055; sbaccess = 3'd2;
        autoinc = 1'b1; readonaddr = 1'b1;
        dw_valid = 1'b1; aw_valid = 1'b1;
        step();
        dw_valid = 1'b0; aw_valid = 1'b0;
        checks++;
        if ({req, we, wdata} !== {1'b1, 1'b1, 32'h0000_0055}) begin
            errors++;
            $display("FAIL prio_write: got %b %b %h expected 1 1 00000055", req, we, wdata);
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h7777_7777;
        step();
        rvalid = 1'b0; rdata = '0;
        checks++;
        if ({sbdata_valid, sbaddress_update, sbaddress_out, busy} !== {2'b01, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL wrap_inc: got %b %b %h %b expected 0 1 00000000 0",
                     sbdata_valid, sbaddress_update, sbaddress_out, busy);
        end
        // New trigger in the cycle right after the response.
        sbaddress = 32'h0000_0010; autoinc = 1'b0; readondata = 1'b1;
        dr_valid = 1'b1;
        step();
        dr_valid = 1'b0;
        checks++;
        if ({busy, req, we, addr} !== {3'b110, 32'h0000_0010}) begin
            errors++;
            $display("FAIL b2b_accept: got %b %b %b %h expected 1 1 0 00000010", busy, req, we, addr);
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rvalid = 1'b1; rdata = 32'h89AB_CDEF;
        step();
        rvalid = 1'b0; rdata = '0;
        checks++;
        if ({sbdata_valid, sbdata_out} !== {1'b1, 32'h89AB_CDEF}) begin
            errors++;
            $display("FAIL b2b_read: got %b %h expected 1 89abcdef", sbdata_valid, sbdata_out);
        end
        readonaddr = 1'b0; readondata = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write32();
        test_read8_autoinc();
        test_write16_lanes();
        test_precheck();
        test_timeout();
        test_bus_error();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_sba_ctrl.md
# dm_sba_ctrl

System-bus-access sequencer for the Debug Module. Consumes the access triggers and configuration fields produced by the SBA register block (address write, data read, data write; sbaccess, autoincrement, readonaddr, readondata). Runs one 32-bit bus transaction at a time over a req/gnt/rvalid master port, and returns sbbusy, sberror and read data to the register block. Sits between the SBA register file and the system interconnect.

## Interface
- TIMEOUT_CYCLES, 256, cycles from first req_o to rvalid_i before the access aborts with a timeout error
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- sbaddress_i  in  32  current sbaddress from the register block
- sbdata_i  in  32  write data from the register block
- sbaccess_i  in  3  access size: 0=8b, 1=16b, 2=32b
- sbautoincrement_i / sbreadonaddr_i / sbreadondata_i  in  1 each  sbcs configuration bits
- sbaddress_write_valid_i / sbdata_read_valid_i / sbdata_write_valid_i  in  1 each  single-cycle triggers
- sbbusy_o  out  1  transaction in progress
- sberror_o  out  3  error code; valid with sberror_valid_o
- sberror_valid_o  out  1  one-cycle error strobe
- sbdata_o  out  32  read data, zero-extended; valid with sbdata_valid_o
- sbdata_valid_o  out  1  one-cycle read-data strobe
- sbaddress_o  out  32  auto-incremented address; valid with sbaddress_update_o
- sbaddress_update_o  out  1  one-cycle address-update strobe
- req_o, we_o  out  1 each  bus request and write enable
- addr_o  out  32  word-aligned bus address ({addr[31:2],2'b00})
- wdata_o  out  32  lane-shifted write data
- be_o  out  4  byte enables
- gnt_i, rvalid_i, err_i  in  1 each  grant, response valid, response error (err_i sampled with rvalid_i)
- rdata_i  in  32  read response data

## Operation
- States: IDLE, REQ, WAIT.
- sbbusy_o = (state != IDLE).
- In IDLE, trigger priority: data_write > address_write (only when sbreadonaddr_i=1) > data_read (only when sbreadondata_i=1). The chosen op latches sbaddress_i, sbdata_i, sbaccess_i and the op type.
- Triggers arriving while not IDLE are ignored. The register block owns sbbusyerror.
- Pre-checks at trigger, no bus activity on failure:
  - sbaccess_i > 2 -> sberror 4 (unsupported size).
  - Misaligned address (16b with addr[0]=1; 32b with addr[1:0]!=0) -> sberror 3 (alignment).
  - In both cases pulse sberror_valid_o and stay IDLE.
- REQ: req_o=1 and held stable until gnt_i. On gnt_i -> WAIT.
- WAIT: on rvalid_i -> IDLE.
  - err_i=1 -> sberror 2 (bad address); no data strobe; no increment.
  - Otherwise, for reads: sbdata_o = (rdata_i >> 8*addr[1:0]), masked to the access size; pulse sbdata_valid_o.
  - On success with sbautoincrement_i=1: sbaddress_o = addr + (1<<sbaccess) mod 2^32; pulse sbaddress_update_o.
- Write lanes:
  - wdata_o = sbdata << 8*addr[1:0].
  - be_o is 4'b0001, 4'b0011 or 4'b1111 for 8b/16b/32b, shifted left by addr[1:0].
  - be_o = 4'b1111 on reads.
- Timeout: a counter clears on leaving IDLE and increments every cycle in REQ/WAIT. When it reaches TIMEOUT_CYCLES: sberror 1, req_o drops, -> IDLE. A late rvalid_i in IDLE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- Trigger in cycle T -> req_o and sbbusy_o high in T+1. Zero-wait gnt means req_o lasts exactly one cycle.
- rvalid_i never arrives in the same cycle as gnt_i. Any such pulse is ignored.
- rvalid_i in cycle R -> strobes (data/error/address) in R+1 and sbbusy_o low in R+1. A new trigger is accepted in R+1.
- Pre-check error: sberror_valid_o in T+1, sbbusy_o never asserts.
- Address wrap: 0xFFFF_FFFC + 4 -> 0x0000_0000.
- Reset asserted mid-transaction: immediate return to IDLE, req_o low, the outstanding response is discarded.

## Structure
- dm package gains:
  - sba_state_e {IDLE, REQ, WAIT}
  - sberror constants: SBERR_NONE=0, SBERR_TIMEOUT=1, SBERR_BADADDR=2, SBERR_ALIGN=3, SBERR_SIZE=4
  - functions sba_be(size, off) and sba_align_ok(size, addr)
- One sub-module: dm_sba_timeout (parameterised counter with clear/enable/expired).

## Test plan
- 32b write, addr 0x1000_0004, data 0xDEADBEEF, gnt in T+3 -> req_o held 3 cycles, be_o=1111, wdata_o=0xDEADBEEF, busy low after rvalid.
- 8b read, addr 0x2000_0003, rdata_i 0xAB00_0000, autoincrement=1 -> sbdata_o=0x0000_00AB, sbaddress_o=0x2000_0004.
- 16b access at 0x3001 -> sberror 3 in T+1, req_o never asserts; sbaccess=3 -> sberror 4.
- No rvalid with TIMEOUT_CYCLES=8 -> sberror 1 at cycle 8 after req_o, req_o drops, a later rvalid is ignored.
- rvalid with err_i=1 on a read with autoincrement -> sberror 2, no sbdata_valid_o, no address update.
- Reset pulsed in WAIT -> all outputs 0 next edge; simultaneous write and address triggers in IDLE -> write executes, address trigger dropped.
